dual_issue_ctrl: RTL and testbench
==================================

Name: dual_issue_ctrl

Overview:
- Issue controller between the two-wide fetch stage and the decode/execute pipeline.
- Each cycle it inspects the fetched pair (slot A, then B in program order) and issues both, A only, or nothing.
- Splits a pair when intra-pair hazards exist, holding B in a one-entry buffer.
- Drives the fetch hold input so PC advances by 8 only when the pair has been fully consumed.

Parameters:
- DATA_WIDTH, 32, instruction width.
- CNT_WIDTH, 16, width of the saturating split-event counter.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  reset; asynchronous, active-low.
- InstrA_i  input  DATA_WIDTH  older instruction of the fetched pair.
- InstrB_i  input  DATA_WIDTH  younger instruction of the fetched pair.
- PairValid_i  input  1  fetched pair is valid this cycle.
- DownReady_i  input  1  decode stage accepts an issue packet this cycle.
- Flush_i  input  1  redirect; discard buffered and in-flight issue.
- FetchStall_o  output  1  combinational; 1 holds fetch PC (drives fetch PCSrc_i).
- Issue0Instr_o  output  DATA_WIDTH  registered slot-0 instruction.
- Issue0Valid_o  output  1  slot-0 valid.
- Issue1Instr_o  output  DATA_WIDTH  registered slot-1 instruction.
- Issue1Valid_o  output  1  slot-1 valid.
- SplitCount_o  output  CNT_WIDTH  count of split pairs, saturating.

Behaviour:
- Reset (rst=0, async): state=PAIR; buffer invalid; Issue*Instr_o=0; Issue*Valid_o=0; SplitCount_o=0.
- Latency: issue outputs are registered and appear the cycle after the decision. FetchStall_o is combinational from state and inputs.
- Decode uses opcode[6:0], rd[11:7], rs1[19:15], rs2[24:20].
- Writes rd: OP 0110011, OP-IMM 0010011, LOAD 0000011, LUI 0110111, AUIPC 0010111, JAL 1101111, JALR 1100111.
- Reads rs1: OP, OP-IMM, LOAD, STORE 0100011, BRANCH 1100011, JALR.
- Reads rs2: OP, STORE, BRANCH.
- Hazard (split pair) if any of:
  - RAW: A writes rd≠0 and B reads a source equal to A.rd.
  - WAW: both write the same rd≠0.
  - Both are LOAD/STORE (single memory port).
  - A is BRANCH/JAL/JALR.
- x0 never creates a hazard.
- State PAIR:
  - Flush_i=1: valids←0, buffer cleared, FetchStall_o=0.
  - DownReady_i=0: outputs hold their values, FetchStall_o=1.
  - PairValid_i=0: valids←0, FetchStall_o=0.
  - No hazard: slot0←A, slot1←B, both valid, FetchStall_o=0.
  - Hazard: slot0←A valid, slot1 invalid, buffer←B, FetchStall_o=1, SplitCount_o+1 (saturates at all-ones), next HOLD_B.
- State HOLD_B:
  - Flush_i=1: valids←0, buffer dropped, next PAIR, FetchStall_o=0.
  - DownReady_i=0: outputs and buffer hold, FetchStall_o=1.
  - Otherwise: slot0←buffer valid, slot1 invalid, FetchStall_o=0, next PAIR. Fetch input is ignored this cycle.
- Priority: Flush_i > DownReady_i=0 > normal issue.
- Flush in the same cycle as a hazard: the flush wins, no split is counted, and the state stays PAIR.
- Issue1Valid_o=1 never occurs while Issue0Valid_o=0.
- Reset asserted mid-HOLD_B drops the buffered instruction immediately.

Test Plan:
- Independent pair: A=0x00500093 (addi x1,x0,5), B=0x00700193 (addi x3,x0,7), ready=1.
  -> next cycle both valid with A/B, FetchStall_o=0, SplitCount_o=0.
- RAW split: A=0x00500093, B=0x00108133 (add x2,x1,x1).
  -> cycle1: FetchStall_o=1, slot0=A valid, slot1 invalid.
  -> cycle2: slot0=0x00108133, FetchStall_o=0.
  -> SplitCount_o=1.
- x0 exemption: A=0x00000013 (nop), B=0x00000133 (add x2,x0,x0) -> dual issue, no split.
- Memory conflict: A=0x00002283 (lw x5,0(x0)), B=0x00002223 (sw x0,4(x0)) -> split, B issued alone next cycle.
- Backpressure and flush: split pair, then DownReady_i=0 for 3 cycles in HOLD_B.
  -> outputs and FetchStall_o=1 held.
  -> then Flush_i=1: valids 0, state PAIR, buffered B never issued.
- Counter saturation with CNT_WIDTH=2: 5 consecutive split pairs -> SplitCount_o stops at 3.
- Async reset mid-HOLD_B: rst low between clock edges -> valids and counter 0 immediately, no slot0 issue after release.

Source files
------------

// File: rtl/dual_issue_ctrl_if.sv
// Fetch-pair / issue-packet bundle between the fetch stage, the dual-issue
// controller and decode.
interface dual_issue_ctrl_if #(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 16
) ();
  logic [DATA_WIDTH-1:0] InstrA_i;
  logic [DATA_WIDTH-1:0] InstrB_i;
  logic                  PairValid_i;
  logic                  DownReady_i;
  logic                  Flush_i;
  logic                  FetchStall_o;
  logic [DATA_WIDTH-1:0] Issue0Instr_o;
  logic                  Issue0Valid_o;
  logic [DATA_WIDTH-1:0] Issue1Instr_o;
  logic                  Issue1Valid_o;
  logic [CNT_WIDTH-1:0]  SplitCount_o;

  modport slave (
    input  InstrA_i, InstrB_i, PairValid_i, DownReady_i, Flush_i,
    output FetchStall_o, Issue0Instr_o, Issue0Valid_o,
           Issue1Instr_o, Issue1Valid_o, SplitCount_o
  );

  modport master (
    output InstrA_i, InstrB_i, PairValid_i, DownReady_i, Flush_i,
    input  FetchStall_o, Issue0Instr_o, Issue0Valid_o,
           Issue1Instr_o, Issue1Valid_o, SplitCount_o
  );
endinterface

// File: rtl/dual_issue_ctrl.sv
// Dual-issue controller: issues the fetched pair together, or splits it on an
// intra-pair hazard and issues the younger instruction from a one-entry buffer.
module dual_issue_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 16
) (
  input logic         clk,
  input logic         rst,
  dual_issue_ctrl_if.slave bus
);

  typedef enum logic [0:0] {PAIR, HOLD_B} state_t;

  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_OPIMM  = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  function automatic logic writes_rd(input logic [6:0] op);
    return (op == OP_OP) || (op == OP_OPIMM) || (op == OP_LOAD) ||
           (op == OP_LUI) || (op == OP_AUIPC) || (op == OP_JAL) ||
           (op == OP_JALR);
  endfunction

  function automatic logic reads_rs1(input logic [6:0] op);
    return (op == OP_OP) || (op == OP_OPIMM) || (op == OP_LOAD) ||
           (op == OP_STORE) || (op == OP_BRANCH) || (op == OP_JALR);
  endfunction

  function automatic logic reads_rs2(input logic [6:0] op);
    return (op == OP_OP) || (op == OP_STORE) || (op == OP_BRANCH);
  endfunction

  function automatic logic is_mem(input logic [6:0] op);
    return (op == OP_LOAD) || (op == OP_STORE);
  endfunction

  function automatic logic is_ctrl(input logic [6:0] op);
    return (op == OP_BRANCH) || (op == OP_JAL) || (op == OP_JALR);
  endfunction

  state_t                state_q;
  logic [DATA_WIDTH-1:0] buf_q;
  logic [DATA_WIDTH-1:0] issue0_instr_q;
  logic [DATA_WIDTH-1:0] issue1_instr_q;
  logic                  issue0_vld_q;
  logic                  issue1_vld_q;
  logic [CNT_WIDTH-1:0]  split_cnt_q;
  logic [CNT_WIDTH-1:0]  split_cnt_d;

  logic [6:0] op_a, op_b;
  logic [4:0] rd_a, rd_b, rs1_b, rs2_b;
  logic       wr_a, wr_b;
  logic       raw_hz, waw_hz, mem_hz, ctrl_hz, hazard;
  logic       unused_instr_bits;

  assign op_a  = bus.InstrA_i[6:0];
  assign rd_a  = bus.InstrA_i[11:7];
  assign op_b  = bus.InstrB_i[6:0];
  assign rd_b  = bus.InstrB_i[11:7];
  assign rs1_b = bus.InstrB_i[19:15];
  assign rs2_b = bus.InstrB_i[24:20];

  // Funct and immediate fields carry no dependency information.
  assign unused_instr_bits = ^{bus.InstrA_i[DATA_WIDTH-1:12], bus.InstrB_i[DATA_WIDTH-1:25],
                               bus.InstrB_i[14:12]};

  // x0 destinations are filtered here so no rule below can fire on them.
  assign wr_a = writes_rd(op_a) && (rd_a != 5'd0);
  assign wr_b = writes_rd(op_b) && (rd_b != 5'd0);

  assign raw_hz  = wr_a && ((reads_rs1(op_b) && (rs1_b == rd_a)) ||
                            (reads_rs2(op_b) && (rs2_b == rd_a)));
  assign waw_hz  = wr_a && wr_b && (rd_a == rd_b);
  assign mem_hz  = is_mem(op_a) && is_mem(op_b);
  assign ctrl_hz = is_ctrl(op_a);
  assign hazard  = raw_hz || waw_hz || mem_hz || ctrl_hz;

  assign split_cnt_d = (&split_cnt_q) ? split_cnt_q : split_cnt_q + 1'b1;

  always_comb begin
    bus.FetchStall_o = 1'b0;
    if (bus.Flush_i) begin
      bus.FetchStall_o = 1'b0;
    end else if (!bus.DownReady_i) begin
      bus.FetchStall_o = 1'b1;
    end else if ((state_q == PAIR) && bus.PairValid_i && hazard) begin
      bus.FetchStall_o = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= PAIR;
      buf_q          <= '0;
      issue0_instr_q <= '0;
      issue1_instr_q <= '0;
      issue0_vld_q   <= 1'b0;
      issue1_vld_q   <= 1'b0;
      split_cnt_q    <= '0;
    end else if (bus.Flush_i) begin
      issue0_vld_q <= 1'b0;
      issue1_vld_q <= 1'b0;
      state_q      <= PAIR;
    end else if (bus.DownReady_i) begin
      case (state_q)
        PAIR: begin
          if (!bus.PairValid_i) begin
            issue0_vld_q <= 1'b0;
            issue1_vld_q <= 1'b0;
          end else if (hazard) begin
            issue0_instr_q <= bus.InstrA_i;
            issue0_vld_q   <= 1'b1;
            issue1_vld_q   <= 1'b0;
            buf_q          <= bus.InstrB_i;
            split_cnt_q    <= split_cnt_d;
            state_q        <= HOLD_B;
          end else begin
            issue0_instr_q <= bus.InstrA_i;
            issue1_instr_q <= bus.InstrB_i;
            issue0_vld_q   <= 1'b1;
            issue1_vld_q   <= 1'b1;
          end
        end
        HOLD_B: begin
          // The fetch pair is still the one already split; only B is pending.
          issue0_instr_q <= buf_q;
          issue0_vld_q   <= 1'b1;
          issue1_vld_q   <= 1'b0;
          state_q        <= PAIR;
        end
        default: state_q <= PAIR;
      endcase
    end
  end

  assign bus.Issue0Instr_o = issue0_instr_q;
  assign bus.Issue0Valid_o = issue0_vld_q;
  assign bus.Issue1Instr_o = issue1_instr_q;
  assign bus.Issue1Valid_o = issue1_vld_q;
  assign bus.SplitCount_o  = split_cnt_q;

endmodule

// File: tb/tb_dual_issue_ctrl.sv
// Bench for dual_issue_ctrl: directed pairs, saturation on a 2-bit counter copy,
// async reset in HOLD_B and random traffic against a behavioural model.
module tb_dual_issue_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] a = '0, b = '0;
  logic pv = 1'b0, rdy = 1'b0, fl = 1'b0;

  int checks = 0;
  int errors = 0;

  dual_issue_ctrl_if #(.DATA_WIDTH(32), .CNT_WIDTH(16)) bus16 ();
  dual_issue_ctrl_if #(.DATA_WIDTH(32), .CNT_WIDTH(2))  bus2 ();

  assign bus16.InstrA_i = a;   assign bus2.InstrA_i = a;
  assign bus16.InstrB_i = b;   assign bus2.InstrB_i = b;
  assign bus16.PairValid_i = pv; assign bus2.PairValid_i = pv;
  assign bus16.DownReady_i = rdy; assign bus2.DownReady_i = rdy;
  assign bus16.Flush_i = fl;   assign bus2.Flush_i = fl;

  dual_issue_ctrl #(.DATA_WIDTH(32), .CNT_WIDTH(16)) dut (.clk(clk), .rst(rst_n), .bus(bus16));
  dual_issue_ctrl #(.DATA_WIDTH(32), .CNT_WIDTH(2))  dut_sat (.clk(clk), .rst(rst_n), .bus(bus2));

  // ---------------- reference model ----------------
  bit          m_hold;
  logic [31:0] m_buf, m_i0, m_i1;
  bit          m_v0, m_v1;
  int          m_cnt, m_cnt2;

  function automatic bit rf_wr(logic [6:0] op);
    return op inside {7'h33, 7'h13, 7'h03, 7'h37, 7'h17, 7'h6f, 7'h67};
  endfunction
  function automatic bit rf_r1(logic [6:0] op);
    return op inside {7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h67};
  endfunction
  function automatic bit rf_r2(logic [6:0] op);
    return op inside {7'h33, 7'h23, 7'h63};
  endfunction

  function automatic bit ref_hazard(logic [31:0] x, logic [31:0] y);
    logic [4:0] d;
    d = x[11:7];
    if (x[6:0] inside {7'h63, 7'h6f, 7'h67}) return 1'b1;
    if ((x[6:0] inside {7'h03, 7'h23}) && (y[6:0] inside {7'h03, 7'h23})) return 1'b1;
    if (rf_wr(x[6:0]) && d != 0) begin
      if (rf_r1(y[6:0]) && y[19:15] == d) return 1'b1;
      if (rf_r2(y[6:0]) && y[24:20] == d) return 1'b1;
      if (rf_wr(y[6:0]) && y[11:7] == d) return 1'b1;
    end
    return 1'b0;
  endfunction

  function automatic bit exp_stall();
    if (fl) return 1'b0;
    if (!rdy) return 1'b1;
    if (m_hold) return 1'b0;
    if (!pv) return 1'b0;
    return ref_hazard(a, b);
  endfunction

  task automatic model_reset();
    m_hold = 0; m_buf = '0; m_i0 = '0; m_i1 = '0;
    m_v0 = 0; m_v1 = 0; m_cnt = 0; m_cnt2 = 0;
  endtask

  task automatic model_commit();
    if (!rst_n) model_reset();
    else if (fl) begin m_v0 = 0; m_v1 = 0; m_hold = 0; end
    else if (!rdy) begin end
    else if (m_hold) begin m_i0 = m_buf; m_v0 = 1; m_v1 = 0; m_hold = 0; end
    else if (!pv) begin m_v0 = 0; m_v1 = 0; end
    else if (ref_hazard(a, b)) begin
      m_i0 = a; m_v0 = 1; m_v1 = 0; m_buf = b; m_hold = 1;
      if (m_cnt < 65535) m_cnt++;
      if (m_cnt2 < 3) m_cnt2++;
    end else begin
      m_i0 = a; m_i1 = b; m_v0 = 1; m_v1 = 1;
    end
  endtask

  function automatic logic [83:0] observed();
    return {bus16.Issue0Valid_o, bus16.Issue1Valid_o,
            bus16.Issue0Valid_o ? bus16.Issue0Instr_o : 32'h0,
            bus16.Issue1Valid_o ? bus16.Issue1Instr_o : 32'h0,
            bus16.SplitCount_o, bus2.SplitCount_o};
  endfunction

  function automatic logic [83:0] expected();
    return {m_v0, m_v1, m_v0 ? m_i0 : 32'h0, m_v1 ? m_i1 : 32'h0,
            m_cnt[15:0], m_cnt2[1:0]};
  endfunction

  task automatic drive(logic [31:0] na, logic [31:0] nb, bit npv, bit nrdy, bit nfl);
    a = na; b = nb; pv = npv; rdy = nrdy; fl = nfl;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    drive('0, '0, 1'b0, 1'b1, 1'b0);
    model_reset();
    #12;
    checks++;
    if (observed() !== 84'h0) begin
      errors++; $display("FAIL reset_outputs got %h exp %h", observed(), 84'h0);
    end
    checks++;
    if (bus16.FetchStall_o !== 1'b0) begin
      errors++; $display("FAIL reset_stall got %b exp 0", bus16.FetchStall_o);
    end
    @(posedge clk); #1 rst_n = 1'b1;
  endtask

  typedef struct { logic [31:0] a; logic [31:0] b; bit pv; bit rdy; bit fl; } stim_t;

  task automatic test_directed();
    stim_t s[$];
    s.push_back('{32'h00500093, 32'h00700193, 1, 1, 0}); // independent
    s.push_back('{32'h00500093, 32'h00108133, 1, 1, 0}); // RAW split
    s.push_back('{32'h00500093, 32'h00108133, 1, 1, 0}); // HOLD_B issues B
    s.push_back('{32'h00000013, 32'h00000133, 1, 1, 0}); // x0 exemption
    s.push_back('{32'h00002283, 32'h00002223, 1, 1, 0}); // memory conflict
    s.push_back('{32'h00002283, 32'h00002223, 1, 1, 0});
    s.push_back('{32'h00500093, 32'h00108133, 1, 1, 0}); // split again
    s.push_back('{32'h00500093, 32'h00108133, 1, 0, 0}); // backpressure x3
    s.push_back('{32'h00500093, 32'h00108133, 1, 0, 0});
    s.push_back('{32'h00500093, 32'h00108133, 1, 0, 0});
    s.push_back('{32'h00500093, 32'h00108133, 1, 1, 1}); // flush drops B
    s.push_back('{32'h0, 32'h0, 0, 1, 0});
    s.push_back('{32'h00500093, 32'h00108133, 1, 1, 1}); // flush beats hazard
    s.push_back('{32'h0, 32'h0, 0, 1, 0});
    foreach (s[i]) begin
      drive(s[i].a, s[i].b, s[i].pv, s[i].rdy, s[i].fl);
      @(negedge clk);
      checks++;
      if (bus16.FetchStall_o !== exp_stall()) begin
        errors++; $display("FAIL directed_stall step %0d got %b exp %b", i, bus16.FetchStall_o, exp_stall());
      end
      @(posedge clk); model_commit(); #1;
      checks++;
      if (observed() !== expected()) begin
        errors++; $display("FAIL directed_out step %0d got %h exp %h", i, observed(), expected());
      end
    end
    checks++;
    if (bus16.Issue0Valid_o !== 1'b0) begin
      errors++; $display("FAIL flushed_b_issued got %b exp 0", bus16.Issue0Valid_o);
    end
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 10; i++) begin
      drive(32'h00500093, 32'h00108133, 1'b1, 1'b1, 1'b0);
      @(negedge clk);
      checks++;
      if (bus16.FetchStall_o !== exp_stall()) begin
        errors++; $display("FAIL sat_stall step %0d got %b exp %b", i, bus16.FetchStall_o, exp_stall());
      end
      @(posedge clk); model_commit(); #1;
      checks++;
      if (observed() !== expected()) begin
        errors++; $display("FAIL sat_out step %0d got %h exp %h", i, observed(), expected());
      end
    end
    checks++;
    if (bus2.SplitCount_o !== 2'd3) begin
      errors++; $display("FAIL sat_count got %0d exp 3", bus2.SplitCount_o);
    end
  endtask

  task automatic test_async_reset();
    drive(32'h00500093, 32'h00108133, 1'b1, 1'b1, 1'b0);
    @(posedge clk); model_commit(); #1;
    drive('0, '0, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    model_reset();
    #1;
    checks++;
    if (observed() !== 84'h0) begin
      errors++; $display("FAIL async_reset got %h exp %h", observed(), 84'h0);
    end
    @(posedge clk); #1 rst_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++;
      if (bus16.FetchStall_o !== exp_stall()) begin
        errors++; $display("FAIL arst_stall step %0d got %b exp %b", i, bus16.FetchStall_o, exp_stall());
      end
      @(posedge clk); model_commit(); #1;
      checks++;
      if (observed() !== expected()) begin
        errors++; $display("FAIL arst_out step %0d got %h exp %h", i, observed(), expected());
      end
    end
  endtask

  task automatic test_random();
    logic [31:0] pool [12];
    pool = '{32'h00500093, 32'h00108133, 32'h00700193, 32'h00000013,
             32'h00002283, 32'h00002223, 32'h00208063, 32'h0040006f,
             32'h000080e7, 32'h002081b3, 32'h000011b7, 32'h00310233};
    for (int i = 0; i < 400; i++) begin
      drive(pool[$urandom_range(0, 11)], pool[$urandom_range(0, 11)],
            $urandom_range(0, 99) < 85, $urandom_range(0, 99) < 80,
            $urandom_range(0, 99) < 5);
      @(negedge clk);
      checks++;
      if (bus16.FetchStall_o !== exp_stall()) begin
        errors++; $display("FAIL rand_stall step %0d got %b exp %b", i, bus16.FetchStall_o, exp_stall());
      end
      @(posedge clk); model_commit(); #1;
      checks++;
      if (observed() !== expected()) begin
        errors++; $display("FAIL rand_out step %0d got %h exp %h", i, observed(), expected());
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_saturation();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
